// File: rtl/sc_link_channel_mux_pkg.sv
// -----------------------------------------------------------------------------
// sc_link_channel_mux_pkg
// Shared definitions for the stage-controller link and the stage controllers:
//   - link_state_e    : link FSM encoding (IDLE/RUN/DRAIN/DONE)
//   - address_width() : per-lattice address width, 3 * clog2(code distance)
//   - msg_width()     : union-message width, {old_root, updated_root, flags}
//   - *_lsb()         : bit offsets of the union-message fields
// Message layout (MSB..LSB): old_root | updated_root | flags[1:0]
// -----------------------------------------------------------------------------
package sc_link_channel_mux_pkg;

    typedef enum logic [1:0] {
        LINK_IDLE  = 2'd0,
        LINK_RUN   = 2'd1,
        LINK_DRAIN = 2'd2,
        LINK_DONE  = 2'd3
    } link_state_e;

    localparam int FLAGS_W = 2;

    function automatic int address_width(input int code_distance);
        return 3 * $clog2(code_distance);
    endfunction

    function automatic int msg_width(input int code_distance);
        return 2 * address_width(code_distance) + FLAGS_W;
    endfunction

    function automatic int flags_lsb();
        return 0;
    endfunction

    function automatic int updated_root_lsb();
        return FLAGS_W;
    endfunction

    function automatic int old_root_lsb(input int code_distance);
        return FLAGS_W + address_width(code_distance);
    endfunction

endpackage

// File: rtl/sc_link_fifo.sv
// -----------------------------------------------------------------------------
// sc_link_fifo
// First-word-fall-through queue for the stage-controller link.
// Ports:
//   clk, reset      : clock, synchronous active-low reset (pointers only)
//   clear           : discard all contents; wins over push/pop in the same cycle
//   push, push_data : write one entry (caller never pushes when full without a pop)
//   pop             : consume the head (caller never pops when empty)
//   pop_data        : current head, forced to zero while empty
//   count           : occupancy 0..DEPTH
//   full, empty     : status flags
// -----------------------------------------------------------------------------
module sc_link_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data only; it is never reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count    = wr_ptr - rd_ptr;
    // Zero the head while empty so stale or uninitialised storage never shows.
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sc_link_channel_mux.sv
// -----------------------------------------------------------------------------
// sc_link_channel_mux
// Merges NUM_CHANNELS local union-message producers through a round-robin
// arbiter into one FWFT queue that feeds the neighbouring sc_fifo_in port.
// Tracks messages accepted per decoding round and provides a drain barrier.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   new_round_start       : pulse; flush queue, clear msg_count, enter RUN
//   drain_req             : level; stop accepting, empty the queue, then DONE
//   in_data/in_valid      : channel i at in_data[i*MSG_WIDTH +: MSG_WIDTH]
//   in_ready              : one-hot grant (or zero), combinational
//   out_data/out_valid    : queue head / queue non-empty
//   out_ready             : downstream accepts the head
//   has_message_flying    : messages pending in this link
//   fifo_count            : queue occupancy
//   msg_count             : saturating count of messages accepted this round
//   drained               : barrier reached (state DONE)
//   link_state            : IDLE=0 RUN=1 DRAIN=2 DONE=3
// -----------------------------------------------------------------------------
module sc_link_channel_mux
    import sc_link_channel_mux_pkg::*;
#(
    parameter int CODE_DISTANCE = 5,
    parameter int NUM_CHANNELS  = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int COUNTER_WIDTH = 16,
    localparam int MSG_WIDTH    = msg_width(CODE_DISTANCE),
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              new_round_start,
    input  logic                              drain_req,
    input  logic [NUM_CHANNELS*MSG_WIDTH-1:0] in_data,
    input  logic [NUM_CHANNELS-1:0]           in_valid,
    output logic [NUM_CHANNELS-1:0]           in_ready,
    output logic [MSG_WIDTH-1:0]              out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              has_message_flying,
    output logic [CNT_W-1:0]                  fifo_count,
    output logic [COUNTER_WIDTH-1:0]          msg_count,
    output logic                              drained,
    output logic [1:0]                        link_state
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    link_state_e              state_q;
    link_state_e              state_d;
    logic [CH_W-1:0]          rr_ptr;
    logic [CH_W-1:0]          grant_idx;
    logic [CH_W-1:0]          next_rr;
    logic [NUM_CHANNELS-1:0]  grant;
    logic                     grant_found;
    logic                     arb_enable;
    logic                     push;
    logic                     pop;
    logic [MSG_WIDTH-1:0]     push_data;
    logic                     fifo_full;
    logic                     fifo_empty;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
        return (&v) ? v : v + COUNTER_WIDTH'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Arbiter
    // -------------------------------------------------------------------------
    assign pop = out_valid && out_ready;

    // A full queue may still accept when the head leaves in the same cycle.
    // new_round_start flushes the queue, so nothing is granted that cycle
    // rather than accepting a message that would be thrown away.
    assign arb_enable = (state_q == LINK_RUN) && !drain_req && !new_round_start
                        && (!fifo_full || pop);

    always_comb begin : arbiter
        int            cand;
        logic [CH_W-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant       = '0;
        grant_idx   = rr_ptr;
        grant_found = 1'b0;
        if (arb_enable) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                cand     = (int'(rr_ptr) + k) % NUM_CHANNELS;
                cand_idx = CH_W'(cand);
                if (!grant_found && in_valid[cand_idx]) begin
                    grant_found      = 1'b1;
                    grant_idx        = cand_idx;
                    grant[cand_idx]  = 1'b1;
                end
            end
        end
    end

    always_comb begin : data_select
        push_data = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (grant[k]) push_data = in_data[k*MSG_WIDTH +: MSG_WIDTH];
        end
    end

    assign push     = grant_found;
    assign in_ready = grant;
    assign next_rr  = (grant_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);

    // -------------------------------------------------------------------------
    // Link FSM
    // -------------------------------------------------------------------------
    always_comb begin : fsm_next
        state_d = state_q;
        if (new_round_start) begin
            state_d = LINK_RUN;
        end else begin
            case (state_q)
                LINK_IDLE:  state_d = LINK_IDLE;
                LINK_RUN:   if (drain_req) state_d = LINK_DRAIN;
                // The barrier cannot be cancelled by dropping drain_req.
                LINK_DRAIN: if (fifo_empty) state_d = LINK_DONE;
                LINK_DONE:  state_d = LINK_DONE;
                default:    state_d = LINK_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= LINK_IDLE;
            rr_ptr    <= '0;
            msg_count <= '0;
        end else begin
            state_q <= state_d;
            if (new_round_start) begin
                msg_count <= '0;
            end else if (push) begin
                msg_count <= sat_inc(msg_count);
            end
            if (push) rr_ptr <= next_rr;
        end
    end

    // -------------------------------------------------------------------------
    // Queue
    // -------------------------------------------------------------------------
    sc_link_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MSG_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (new_round_start),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign link_state = state_q;
    assign drained    = (state_q == LINK_DONE);

    // Producers with valid asserted during RUN count as in flight even before
    // they are granted, so the stage controller does not declare the round idle.
    assign has_message_flying = (state_q != LINK_IDLE)
                                && (!fifo_empty || (state_q == LINK_RUN && |in_valid));

endmodule

// File: tb/tb_sc_link_channel_mux.sv
module tb_sc_link_channel_mux;

    localparam int NCH   = 4;
    localparam int MW    = 20;   // 2*3*clog2(5)+2
    localparam int CW    = 4;    // narrow counter so saturation is reachable
    localparam int CNT_W = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                new_round_start = 1'b0;
    logic                drain_req = 1'b0;
    logic [NCH*MW-1:0]   in_data = '0;
    logic [NCH-1:0]      in_valid = '0;
    logic [NCH-1:0]      in_ready;
    logic [MW-1:0]       out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                has_message_flying;
    logic [CNT_W-1:0]    fifo_count;
    logic [CW-1:0]       msg_count;
    logic                drained;
    logic [1:0]          link_state;

    int vectors = 0;
    int miscompares = 0;

    sc_link_channel_mux #(
        .CODE_DISTANCE (5),
        .NUM_CHANNELS  (NCH),
        .FIFO_DEPTH    (8),
        .COUNTER_WIDTH (CW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .new_round_start    (new_round_start),
        .drain_req          (drain_req),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .has_message_flying (has_message_flying),
        .fifo_count         (fifo_count),
        .msg_count          (msg_count),
        .drained            (drained),
        .link_state         (link_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [MW-1:0] v);
        in_data[ch*MW +: MW] = v;
    endtask

    task automatic pulse_new_round();
        new_round_start = 1'b1;
        tick();
        new_round_start = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 4'hF;
        repeat (3) tick();
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_in_ready got=%b want=0000", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        vectors++; if (out_data !== 20'h0) begin miscompares++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        vectors++; if (link_state !== 2'd0) begin miscompares++; $display("FAIL reset_state got=%0d want=0", link_state); end
        vectors++; if (msg_count !== 4'd0) begin miscompares++; $display("FAIL reset_msg_count got=%0d want=0", msg_count); end
        vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL reset_fifo_count got=%0d want=0", fifo_count); end
        vectors++; if (drained !== 1'b0) begin miscompares++; $display("FAIL reset_drained got=%b want=0", drained); end
        vectors++; if (has_message_flying !== 1'b0) begin miscompares++; $display("FAIL reset_flying got=%b want=0", has_message_flying); end
        reset = 1'b1;
        in_valid = 4'h0;
        tick();
    endtask

    task automatic test_order();
        logic [NCH-1:0] exp_rdy;
        pulse_new_round();
        vectors++; if (link_state !== 2'd1) begin miscompares++; $display("FAIL order_state got=%0d want=1", link_state); end
        for (int i = 0; i < NCH; i++) set_ch(i, MW'(32'h10 + i));
        in_valid = 4'hF;
        out_ready = 1'b1;
        settle();
        for (int k = 0; k < NCH; k++) begin
            exp_rdy = 4'(1 << k);
            vectors++; if (in_ready !== exp_rdy) begin miscompares++; $display("FAIL order_grant%0d got=%b want=%b", k, in_ready, exp_rdy); end
            if (k == 0) begin
                vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL order_no_bypass got=%b want=0", out_valid); end
            end else begin
                vectors++; if (out_valid !== 1'b1 || out_data !== MW'(32'h10 + k - 1)) begin
                    miscompares++; $display("FAIL order_out%0d got=%b/%h want=1/%h", k, out_valid, out_data, MW'(32'h10 + k - 1));
                end
            end
            tick();
            in_valid[k] = 1'b0;
            settle();
        end
        vectors++; if (out_valid !== 1'b1 || out_data !== 20'h13) begin miscompares++; $display("FAIL order_out3 got=%b/%h want=1/13", out_valid, out_data); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL order_empty got=%b want=0", out_valid); end
        vectors++; if (msg_count !== 4'd4) begin miscompares++; $display("FAIL order_msg_count got=%0d want=4", msg_count); end
    endtask

    task automatic test_fairness();
        logic [NCH-1:0] exp_rdy;
        in_valid = 4'hF;
        out_ready = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'(1 << (k % NCH));
            vectors++; if (in_ready !== exp_rdy) begin miscompares++; $display("FAIL fair_grant%0d got=%b want=%b", k, in_ready, exp_rdy); end
            tick();
        end
        vectors++; if (msg_count !== 4'd9) begin miscompares++; $display("FAIL fair_msg_count got=%0d want=9", msg_count); end
        repeat (8) tick();
        vectors++; if (msg_count !== 4'd15) begin miscompares++; $display("FAIL fair_saturate got=%0d want=15", msg_count); end
        vectors++; if (fifo_count !== 4'd1) begin miscompares++; $display("FAIL fair_steady_count got=%0d want=1", fifo_count); end
        in_valid = 4'h0;
        tick();
        vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL fair_empty got=%0d want=0", fifo_count); end
    endtask

    task automatic test_full();
        pulse_new_round();
        vectors++; if (msg_count !== 4'd0) begin miscompares++; $display("FAIL full_msg_clear got=%0d want=0", msg_count); end
        out_ready = 1'b0;
        in_valid = 4'b0100;
        for (int n = 0; n < 8; n++) begin
            set_ch(2, MW'(32'h20 + n));
            settle();
            vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL full_accept%0d got=%b want=0100", n, in_ready); end
            tick();
        end
        set_ch(2, 20'h28);
        settle();
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL full_stall got=%b want=0000", in_ready); end
        vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL full_count got=%0d want=8", fifo_count); end
        vectors++; if (out_data !== 20'h20) begin miscompares++; $display("FAIL full_head got=%h want=20", out_data); end
        vectors++; if (msg_count !== 4'd8) begin miscompares++; $display("FAIL full_msg_count got=%0d want=8", msg_count); end
        out_ready = 1'b1;
        settle();
        vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL full_push_pop_grant got=%b want=0100", in_ready); end
        tick();
        in_valid = 4'h0;
        settle();
        vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL full_push_pop_count got=%0d want=8", fifo_count); end
        vectors++; if (out_data !== 20'h21) begin miscompares++; $display("FAIL full_push_pop_head got=%h want=21", out_data); end
        vectors++; if (msg_count !== 4'd9) begin miscompares++; $display("FAIL full_msg_count2 got=%0d want=9", msg_count); end
    endtask

    task automatic test_drain();
        repeat (3) tick();
        out_ready = 1'b0;
        settle();
        vectors++; if (fifo_count !== 4'd5) begin miscompares++; $display("FAIL drain_start_count got=%0d want=5", fifo_count); end
        vectors++; if (out_data !== 20'h24) begin miscompares++; $display("FAIL drain_start_head got=%h want=24", out_data); end
        drain_req = 1'b1;
        in_valid = 4'hF;
        settle();
        vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL drain_in_ready got=%b want=0000", in_ready); end
        vectors++; if (has_message_flying !== 1'b1) begin miscompares++; $display("FAIL drain_flying got=%b want=1", has_message_flying); end
        tick();
        vectors++; if (link_state !== 2'd2) begin miscompares++; $display("FAIL drain_state got=%0d want=2", link_state); end
        out_ready = 1'b1;
        settle();
        for (int k = 0; k < 5; k++) begin
            vectors++; if (out_data !== MW'(32'h24 + k)) begin miscompares++; $display("FAIL drain_pop%0d got=%h want=%h", k, out_data, MW'(32'h24 + k)); end
            tick();
        end
        vectors++; if (fifo_count !== 4'd0 || link_state !== 2'd2) begin
            miscompares++; $display("FAIL drain_empty got=%0d/%0d want=0/2", fifo_count, link_state);
        end
        vectors++; if (drained !== 1'b0) begin miscompares++; $display("FAIL drain_early got=%b want=0", drained); end
        tick();
        vectors++; if (link_state !== 2'd3) begin miscompares++; $display("FAIL drain_done_state got=%0d want=3", link_state); end
        vectors++; if (drained !== 1'b1) begin miscompares++; $display("FAIL drain_drained got=%b want=1", drained); end
        vectors++; if (has_message_flying !== 1'b0) begin miscompares++; $display("FAIL drain_done_flying got=%b want=0", has_message_flying); end
        drain_req = 1'b0;
        in_valid = 4'h0;
        tick();
        vectors++; if (drained !== 1'b1) begin miscompares++; $display("FAIL drain_hold got=%b want=1", drained); end
    endtask

    task automatic test_restart();
        pulse_new_round();
        vectors++; if (link_state !== 2'd1 || drained !== 1'b0) begin
            miscompares++; $display("FAIL restart_run got=%0d/%b want=1/0", link_state, drained);
        end
        out_ready = 1'b0;
        set_ch(0, 20'h30);
        in_valid = 4'b0001;
        repeat (3) tick();
        in_valid = 4'h0;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        tick();
        vectors++; if (link_state !== 2'd2 || fifo_count !== 4'd3) begin
            miscompares++; $display("FAIL restart_barrier got=%0d/%0d want=2/3", link_state, fifo_count);
        end
        pulse_new_round();
        vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL restart_count got=%0d want=0", fifo_count); end
        vectors++; if (msg_count !== 4'd0) begin miscompares++; $display("FAIL restart_msg got=%0d want=0", msg_count); end
        vectors++; if (link_state !== 2'd1) begin miscompares++; $display("FAIL restart_state got=%0d want=1", link_state); end
        vectors++; if (drained !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL restart_flags got=%b/%b want=0/0", drained, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        set_ch(1, 20'h40);
        in_valid = 4'b0010;
        repeat (2) tick();
        in_valid = 4'h0;
        settle();
        vectors++; if (fifo_count !== 4'd2) begin miscompares++; $display("FAIL midrst_fill got=%0d want=2", fifo_count); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        settle();
        vectors++; if (out_valid !== 1'b0 || out_data !== 20'h0) begin
            miscompares++; $display("FAIL midrst_out got=%b/%h want=0/0", out_valid, out_data);
        end
        vectors++; if (fifo_count !== 4'd0 || link_state !== 2'd0 || msg_count !== 4'd0) begin
            miscompares++; $display("FAIL midrst_state got=%0d/%0d/%0d want=0/0/0", fifo_count, link_state, msg_count);
        end
        in_valid = 4'hF;
        out_ready = 1'b1;
        settle();
        vectors++; if (in_ready !== 4'b0000 || has_message_flying !== 1'b0) begin
            miscompares++; $display("FAIL midrst_idle got=%b/%b want=0000/0", in_ready, has_message_flying);
        end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_no_emit got=%b want=0", out_valid); end
        in_valid = 4'h0;
    endtask

    initial begin
        test_reset();
        test_order();
        test_fairness();
        test_full();
        test_drain();
        test_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
